// File: rtl/alu_mc.sv
// alu_mc: ALU with single-cycle arithmetic/logic/shift/compare operations and
// iterative multiply (shift-add) and divide (restoring), one bit per cycle.
// Results and flags are registered and held under a valid/ready handshake.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_q;
    logic             is_div, neg_lo, neg_hi, div_zero, div_ovf;

    logic             accept, is_multi;

    logic [SHW-1:0]   sh, sh_r_idx, sh_l_idx;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_v, alu_z, alu_n, use_cmp, cmp;

    logic             sgn, sa, sb, div_ge;
    logic [WIDTH-1:0] ma, mb;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fin_r, fin_hi;
    logic             fin_v;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_multi = op[4] && (op[3:2] == 2'b00);

    // Single-cycle ALU result and flags from the live operands
    always_comb begin
        sh       = a[SHW-1:0];
        sh_r_idx = sh - SHW'(1);
        sh_l_idx = SHW'(0) - sh;
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        alu_r    = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        use_cmp  = 1'b0;
        cmp      = 1'b0;
        if (!op[4]) begin
            case (op[3:0])
                4'b0000: begin
                    alu_r = sum[WIDTH-1:0];
                    alu_c = sum[WIDTH];
                end
                4'b0001: begin
                    alu_r = diff[WIDTH-1:0];
                    alu_c = diff[WIDTH];
                end
                4'b0010: begin
                    alu_r = sum[WIDTH-1:0];
                    alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end
                4'b0011: begin
                    alu_r = diff[WIDTH-1:0];
                    alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                end
                4'b0100: alu_r = a & b;
                4'b0101: alu_r = a | b;
                4'b0110: alu_r = a ^ b;
                4'b0111: alu_r = ~(a | b);
                4'b1000, 4'b1001: alu_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
                4'b1010: begin
                    use_cmp = 1'b1;
                    cmp     = diff[WIDTH];
                    alu_r   = {{(WIDTH-1){1'b0}}, cmp};
                end
                4'b1011: begin
                    use_cmp = 1'b1;
                    cmp     = $signed(a) < $signed(b);
                    alu_r   = {{(WIDTH-1){1'b0}}, cmp};
                end
                4'b1100: begin
                    alu_r = $unsigned($signed(b) >>> sh);
                    alu_c = (sh != '0) && b[sh_r_idx];
                end
                4'b1101: begin
                    alu_r = b >> sh;
                    alu_c = (sh != '0) && b[sh_r_idx];
                end
                4'b1110, 4'b1111: begin
                    alu_r = b << sh;
                    alu_c = (sh != '0) && b[sh_l_idx];
                end
            endcase
        end
        alu_z = use_cmp ? (a == b) : (alu_r == '0);
        alu_n = use_cmp ? cmp : alu_r[WIDTH-1];
    end

    // Operand magnitudes, one iteration step, and the final sign/special-case fixup
    always_comb begin
        sgn       = !op[0];
        sa        = sgn && a[WIDTH-1];
        sb        = sgn && b[WIDTH-1];
        ma        = sa ? -a : a;
        mb        = sb ? -b : b;
        mul_sum   = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        if (is_div) begin
            step_hi = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        // The last iteration and the result fixup share one edge, so the fixup
        // works on the step outputs rather than the accumulator registers.
        prod = {step_hi, step_lo};
        if (neg_lo) prod = -prod;
        fin_v = 1'b0;
        if (is_div) begin
            fin_r  = neg_lo ? -step_lo : step_lo;
            fin_hi = neg_hi ? -step_hi : step_hi;
            if (div_zero) begin
                fin_r  = '1;
                fin_hi = a_q;
                fin_v  = 1'b1;
            end else if (div_ovf) begin
                fin_r  = a_q;
                fin_hi = '0;
                fin_v  = 1'b1;
            end
        end else begin
            fin_r  = prod[WIDTH-1:0];
            fin_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM, multiply/divide iteration registers and registered result/flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            a_q       <= '0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            div_zero  <= 1'b0;
            div_ovf   <= 1'b0;
            out_valid <= 1'b0;
            r         <= '0;
            r_hi      <= '0;
            zero      <= 1'b1;
            carry     <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_multi) begin
                        state     <= BUSY;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        is_div    <= op[1];
                        neg_lo    <= sa ^ sb;
                        neg_hi    <= sa;
                        div_zero  <= (b == '0);
                        div_ovf   <= sgn && (a == MOST_NEG) && (b == '1);
                        a_q       <= a;
                        acc_hi    <= '0;
                        acc_lo    <= op[1] ? ma : mb;
                        opnd      <= op[1] ? mb : ma;
                    end else if (accept) begin
                        out_valid <= 1'b1;
                        r         <= alu_r;
                        r_hi      <= '0;
                        zero      <= alu_z;
                        carry     <= alu_c;
                        negative  <= alu_n;
                        overflow  <= alu_v;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + SHW'(1);
                    if (cnt == '1) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        r         <= fin_r;
                        r_hi      <= fin_hi;
                        zero      <= ({fin_hi, fin_r} == '0);
                        carry     <= 1'b0;
                        negative  <= fin_hi[WIDTH-1];
                        overflow  <= fin_v;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors with hand-computed results; expected responses
// go into a scoreboard queue and a negedge monitor pops and compares them
// whenever a result is handed over.
module tb_alu_mc;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [4:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, zero, carry, negative, overflow;
    logic [W-1:0] r, r_hi;

    typedef struct {
        string        name;
        logic [W-1:0] r;
        logic [W-1:0] rhi;
        logic         z, c, n, v;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .r_hi(r_hi), .zero(zero), .carry(carry), .negative(negative),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Monitor: every handed-over result is compared against the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got r=%h r_hi=%h with empty scoreboard", r, r_hi);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({r, r_hi, zero, carry, negative, overflow} !== {e.r, e.rhi, e.z, e.c, e.n, e.v}) begin
                    errors++;
                    $display("FAIL %s: got r=%h r_hi=%h zcnv=%b%b%b%b, expected r=%h r_hi=%h zcnv=%b%b%b%b",
                             e.name, r, r_hi, zero, carry, negative, overflow,
                             e.r, e.rhi, e.z, e.c, e.n, e.v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_push(input string name, input logic [W-1:0] er, input logic [W-1:0] erhi,
                               input logic ez, input logic ec, input logic en, input logic ev);
        exp_t e;
        e.name = name; e.r = er; e.rhi = erhi; e.z = ez; e.c = ec; e.n = en; e.v = ev;
        sb_q.push_back(e);
    endtask

    // Present an op, wait (bounded) for in_ready, return 1 time unit after the accepting edge
    task automatic put(input string name, input logic [4:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] er, input logic [W-1:0] erhi,
                       input logic ez, input logic ec, input logic en, input logic ev, input bit push);
        int n;
        if (push) expect_push(name, er, erhi, ez, ec, en, ev);
        op = o; a = ia; b = ib; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_accept"}, in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic [4:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] er, input logic [W-1:0] erhi,
                         input logic ez, input logic ec, input logic en, input logic ev, input int exp_lat);
        int lat;
        put(name, o, ia, ib, er, erhi, ez, ec, en, ev, 1'b1);
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("reset_flags", {out_valid, zero, carry, negative, overflow, in_ready}, 6'b010001);
        chk("reset_result", {r, r_hi}, 64'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        //          name       op        a             b             r             r_hi          z     c     n     v     lat
        issue("addu_carry", 5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        issue("subu_borrow",5'b00001, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        issue("add_ovf",    5'b00010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        issue("sub_ovf",    5'b00011, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        issue("and",        5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        issue("sltu",       5'b01010, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        issue("slt_false",  5'b01011, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue("slt_equal",  5'b01011, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        issue("sra",        5'b01100, 32'h00000004, 32'h80000018, 32'hF8000001, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        issue("srl",        5'b01101, 32'h00000004, 32'h80000018, 32'h08000001, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        issue("srl_sh0",    5'b01101, 32'h00000000, 32'h80000018, 32'h80000018, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        issue("sll_sh4",    5'b01110, 32'h00000004, 32'h8000000F, 32'h000000F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue("sll_sh1",    5'b01111, 32'h00000001, 32'h8000000F, 32'h0000001E, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        issue("undef_101",  5'b10100, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        issue("undef_11",   5'b11000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1);

        issue("mult_neg",   5'b10000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, W + 1);
        issue("multu_max",  5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0, W + 1);
        issue("mult_zero",  5'b10000, 32'h00000000, 32'h0000007B, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, W + 1);
        issue("div_neg",    5'b10010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, W + 1);
        issue("divu",       5'b10011, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0, W + 1);
        issue("divu_by0",   5'b10011, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'h00001234, 1'b0, 1'b0, 1'b0, 1'b1, W + 1);
        issue("div_ovf",    5'b10010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, W + 1);

        // Back-to-back single-cycle ops, one per edge
        @(posedge clk); #1;
        put("burst_or",  5'b00101, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        put("burst_xor", 5'b00110, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        put("burst_nor", 5'b00111, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        put("burst_lui", 5'b01000, 32'h00000000, 32'h00001234, 32'h12340000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Back-pressure: AND result held for 3 edges, queued OR taken on release
        out_ready = 1'b0;
        put("bp_and", 5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_push("bp_or", 32'h0F0F00F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        op = 5'b00101; a = 32'h0F0F0000; b = 32'h000000F0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold", {out_valid, in_ready, r, r_hi, zero, carry, negative, overflow},
                {1'b1, 1'b0, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_accepted", {out_valid, r}, {1'b1, 32'h0F0F00F0});
        @(posedge clk); #1;

        // Reset during an in-flight divide: aborted, no result, immediate reuse
        put("rst_divu", 5'b10011, 32'h0000FFFF, 32'h00000003, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_async", {out_valid, r, r_hi, zero}, {1'b0, 32'h0, 32'h0, 1'b1});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_release_ready", in_ready, 1);
        issue("rst_addu", 5'b00000, 32'h00000003, 32'h00000004, 32'h00000007, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        repeat (40) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
